// File: rtl/uart_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_core (with helper uart_fifo)                               |
// | Brief    : Full-duplex UART with TX/RX FIFOs, configurable frame format,   |
// |            16x-oversampled majority-vote receiver and sticky error flags.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             w_wr;
    logic             w_rd;
    logic [c_AW-1:0]  w_rd_next;

    // A write while full is dropped even if a read happens in the same cycle.
    assign w_wr      = wr_en && (r_count != c_FULL);
    assign w_rd      = rd_en && (r_count != '0);
    assign w_rd_next = r_rd_ptr + 1'b1;

    assign full    = (r_count == c_FULL);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_head;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Registered first-word fall-through head.
            if (w_wr && (r_count == '0)) begin
                r_head <= wr_data;
            end else if (w_rd) begin
                if (r_count[c_AW:1] != '0) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_wr) begin
                    r_head <= wr_data;
                end
            end
        end
    end
endmodule

module uart_core #(
    parameter int DATA_BITS  = 8,
    parameter int DEPTH      = 16,
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIV_W-1:0]         baud_div,
    input  logic [1:0]               parity_mode,
    input  logic                     two_stop,
    input  logic                     rx,
    output logic                     tx,
    input  logic [DATA_BITS-1:0]     tx_data,
    input  logic                     tx_wr_en,
    output logic                     tx_full,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     tx_busy,
    output logic [DATA_BITS-1:0]     rx_data,
    input  logic                     rx_rd_en,
    output logic                     rx_empty,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     rx_frame_err,
    output logic                     rx_parity_err,
    output logic                     rx_overrun,
    input  logic                     err_clr
);
    localparam int c_SW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_BITS + 1);
    localparam logic [c_SW-1:0] c_S_LAST = c_SW'(OVERSAMPLE - 1);
    localparam logic [c_SW-1:0] c_S_V0   = c_SW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SW-1:0] c_S_V1   = c_SW'(OVERSAMPLE / 2);
    localparam logic [c_SW-1:0] c_S_V2   = c_SW'(OVERSAMPLE / 2 + 1);
    localparam logic [c_BW-1:0] c_B_LAST = c_BW'(DATA_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_BREAK  = 3'd5;

    // ---------------- TX path ----------------
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_tx_empty;
    logic                 w_tx_tick;
    logic                 w_tx_stop_done;
    logic                 w_tx_start;

    logic [2:0]           r_tx_state;
    logic                 r_tx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [c_SW-1:0]      r_tx_s;
    logic [c_BW-1:0]      r_tx_bit;
    logic [DIV_W-1:0]     r_tx_cnt;
    logic [DIV_W-1:0]     r_tx_div;
    logic                 r_tx_par;
    logic                 r_tx_par_en;
    logic                 r_tx_two_stop;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_wr_en),
        .wr_data (tx_data),
        .rd_en   (w_tx_start),
        .rd_data (w_tx_head),
        .full    (tx_full),
        .empty   (w_tx_empty),
        .count   (tx_count)
    );

    assign w_tx_tick      = (r_tx_cnt == r_tx_div);
    assign w_tx_stop_done = (r_tx_state == c_ST_STOP) && w_tx_tick && (r_tx_s == c_S_LAST) &&
                            (r_tx_bit == {{(c_BW-1){1'b0}}, r_tx_two_stop});
    // Back-to-back frames: a pending word starts straight out of the last stop bit.
    assign w_tx_start     = !w_tx_empty && ((r_tx_state == c_ST_IDLE) || w_tx_stop_done);

    assign tx      = r_tx;
    assign tx_busy = (r_tx_state != c_ST_IDLE) || !w_tx_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state    <= c_ST_IDLE;
            r_tx          <= 1'b1;
            r_tx_shift    <= '0;
            r_tx_s        <= '0;
            r_tx_bit      <= '0;
            r_tx_cnt      <= '0;
            r_tx_div      <= '0;
            r_tx_par      <= 1'b0;
            r_tx_par_en   <= 1'b0;
            r_tx_two_stop <= 1'b0;
        end else if (w_tx_start) begin
            r_tx_state    <= c_ST_START;
            r_tx          <= 1'b0;
            r_tx_shift    <= w_tx_head;
            r_tx_s        <= '0;
            r_tx_bit      <= '0;
            r_tx_cnt      <= '0;
            r_tx_div      <= baud_div;
            r_tx_par      <= (^w_tx_head) ^ parity_mode[1];
            r_tx_par_en   <= ^parity_mode;
            r_tx_two_stop <= two_stop;
        end else begin
            r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + 1'b1;
            if (w_tx_tick && (r_tx_state != c_ST_IDLE)) begin
                if (r_tx_s != c_S_LAST) begin
                    r_tx_s <= r_tx_s + 1'b1;
                end else begin
                    r_tx_s <= '0;
                    case (r_tx_state)
                        c_ST_START: begin
                            r_tx_state <= c_ST_DATA;
                            r_tx       <= r_tx_shift[0];
                        end
                        c_ST_DATA: begin
                            if (r_tx_bit == c_B_LAST) begin
                                r_tx_bit <= '0;
                                if (r_tx_par_en) begin
                                    r_tx_state <= c_ST_PARITY;
                                    r_tx       <= r_tx_par;
                                end else begin
                                    r_tx_state <= c_ST_STOP;
                                    r_tx       <= 1'b1;
                                end
                            end else begin
                                r_tx_bit   <= r_tx_bit + 1'b1;
                                r_tx_shift <= r_tx_shift >> 1;
                                r_tx       <= r_tx_shift[1];
                            end
                        end
                        c_ST_PARITY: begin
                            r_tx_state <= c_ST_STOP;
                            r_tx       <= 1'b1;
                        end
                        c_ST_STOP: begin
                            if (w_tx_stop_done) begin
                                r_tx_state <= c_ST_IDLE;
                            end else begin
                                r_tx_bit <= r_tx_bit + 1'b1;
                            end
                        end
                        default: begin
                            r_tx_state <= c_ST_IDLE;
                            r_tx       <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- RX path ----------------
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [2:0]           r_rx_state;
    logic [DIV_W-1:0]     r_rx_cnt;
    logic [DIV_W-1:0]     r_rx_div;
    logic [c_SW-1:0]      r_rx_s;
    logic [c_BW-1:0]      r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_v0;
    logic                 r_rx_v1;
    logic                 r_rx_par_en;
    logic                 r_rx_par_odd;
    logic                 r_rx_push;
    logic [DATA_BITS-1:0] r_rx_word;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic                 w_rx_tick;
    logic                 w_rx_vote;
    logic                 w_rx_vote_now;
    logic                 w_rx_full;
    logic                 w_frame_set;
    logic                 w_parity_set;
    logic                 w_overrun_set;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_rx_push),
        .wr_data (r_rx_word),
        .rd_en   (rx_rd_en),
        .rd_data (rx_data),
        .full    (w_rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    assign w_rx_tick     = (r_rx_cnt == r_rx_div);
    assign w_rx_vote     = (r_rx_v0 & r_rx_v1) | (r_rx_v0 & r_rx_sync) | (r_rx_v1 & r_rx_sync);
    assign w_rx_vote_now = w_rx_tick && (r_rx_s == c_S_V2);
    assign w_parity_set  = w_rx_vote_now && (r_rx_state == c_ST_PARITY) &&
                           (w_rx_vote != ((^r_rx_shift) ^ r_rx_par_odd));
    assign w_frame_set   = w_rx_vote_now && (r_rx_state == c_ST_STOP) && !w_rx_vote;
    assign w_overrun_set = r_rx_push && w_rx_full;

    assign rx_frame_err  = r_frame_err;
    assign rx_parity_err = r_parity_err;
    assign rx_overrun    = r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state   <= c_ST_IDLE;
            r_rx_cnt     <= '0;
            r_rx_div     <= '0;
            r_rx_s       <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_v0      <= 1'b1;
            r_rx_v1      <= 1'b1;
            r_rx_par_en  <= 1'b0;
            r_rx_par_odd <= 1'b0;
            r_rx_push    <= 1'b0;
            r_rx_word    <= '0;
        end else begin
            r_rx_push <= 1'b0;
            // The divisor only reloads at a wrap while idle, so it is frozen for the frame.
            if (w_rx_tick) begin
                r_rx_cnt <= '0;
                if (r_rx_state == c_ST_IDLE) begin
                    r_rx_div <= baud_div;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end

            if (r_rx_state == c_ST_BREAK) begin
                if (r_rx_sync) begin
                    r_rx_state <= c_ST_IDLE;
                end
            end else if (r_rx_state == c_ST_IDLE) begin
                if (w_rx_tick && !r_rx_sync) begin
                    // The detecting tick is sample 0 of the start bit.
                    r_rx_state   <= c_ST_START;
                    r_rx_s       <= {{(c_SW-1){1'b0}}, 1'b1};
                    r_rx_bit     <= '0;
                    r_rx_par_en  <= ^parity_mode;
                    r_rx_par_odd <= parity_mode[1];
                end
            end else if (w_rx_tick) begin
                r_rx_s <= (r_rx_s == c_S_LAST) ? '0 : r_rx_s + 1'b1;
                if (r_rx_s == c_S_V0) begin
                    r_rx_v0 <= r_rx_sync;
                end
                if (r_rx_s == c_S_V1) begin
                    r_rx_v1 <= r_rx_sync;
                end
                case (r_rx_state)
                    c_ST_START: begin
                        if (w_rx_vote_now && w_rx_vote) begin
                            r_rx_state <= c_ST_IDLE;
                        end else if (r_rx_s == c_S_LAST) begin
                            r_rx_state <= c_ST_DATA;
                        end
                    end
                    c_ST_DATA: begin
                        if (w_rx_vote_now) begin
                            r_rx_shift <= {w_rx_vote, r_rx_shift[DATA_BITS-1:1]};
                        end
                        if (r_rx_s == c_S_LAST) begin
                            if (r_rx_bit == c_B_LAST) begin
                                r_rx_bit   <= '0;
                                r_rx_state <= r_rx_par_en ? c_ST_PARITY : c_ST_STOP;
                            end else begin
                                r_rx_bit <= r_rx_bit + 1'b1;
                            end
                        end
                    end
                    c_ST_PARITY: begin
                        if (r_rx_s == c_S_LAST) begin
                            r_rx_state <= c_ST_STOP;
                        end
                    end
                    c_ST_STOP: begin
                        if (w_rx_vote_now) begin
                            if (w_rx_vote) begin
                                r_rx_push  <= 1'b1;
                                r_rx_word  <= r_rx_shift;
                                r_rx_state <= c_ST_IDLE;
                            end else begin
                                r_rx_state <= c_ST_BREAK;
                            end
                        end
                    end
                    default: r_rx_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    // Set events take priority over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_parity_set) begin
                r_parity_err <= 1'b1;
            end else if (err_clr) begin
                r_parity_err <= 1'b0;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_core                                                    |
// | Brief    : Directed self-checking bench for uart_core (DEPTH=4, div=0).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_core;
    localparam int c_DB    = 8;
    localparam int c_DEPTH = 4;
    localparam int c_DIVW  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [c_DIVW-1:0] baud_div = '0;
    logic [1:0]        parity_mode = 2'b00;
    logic              two_stop = 1'b0;
    logic              tx;
    logic [c_DB-1:0]   tx_data = '0;
    logic              tx_wr_en = 1'b0;
    logic              tx_full;
    logic [2:0]        tx_count;
    logic              tx_busy;
    logic [c_DB-1:0]   rx_data;
    logic              rx_rd_en = 1'b0;
    logic              rx_empty;
    logic [2:0]        rx_count;
    logic              rx_frame_err;
    logic              rx_parity_err;
    logic              rx_overrun;
    logic              err_clr = 1'b0;
    logic              loop_en = 1'b0;
    logic              rx_drv = 1'b1;
    logic              rx_line;

    int checks = 0;
    int failures = 0;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_core #(.DATA_BITS(c_DB), .DEPTH(c_DEPTH), .DIV_W(c_DIVW), .OVERSAMPLE(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_div      (baud_div),
        .parity_mode   (parity_mode),
        .two_stop      (two_stop),
        .rx            (rx_line),
        .tx            (tx),
        .tx_data       (tx_data),
        .tx_wr_en      (tx_wr_en),
        .tx_full       (tx_full),
        .tx_count      (tx_count),
        .tx_busy       (tx_busy),
        .rx_data       (rx_data),
        .rx_rd_en      (rx_rd_en),
        .rx_empty      (rx_empty),
        .rx_count      (rx_count),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun),
        .err_clr       (err_clr)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_frame(input logic [11:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx_drv = bits[i];
            repeat (16) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        checks++; if (tx_count !== 3'd0 || tx_full !== 1'b0) begin failures++; $display("FAIL reset_txfifo: count %0d full %b expected 0 0", tx_count, tx_full); end
        checks++; if (rx_count !== 3'd0 || rx_empty !== 1'b1) begin failures++; $display("FAIL reset_rxfifo: count %0d empty %b expected 0 1", rx_count, rx_empty); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rxdata: got %h expected 00", rx_data); end
        checks++; if ({rx_frame_err, rx_parity_err, rx_overrun} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {rx_frame_err, rx_parity_err, rx_overrun}); end
    endtask

    task automatic test_tx_a5;
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        loop_en = 1'b0; parity_mode = 2'b00; two_stop = 1'b0;
        @(negedge clk); tx_data = 8'hA5; tx_wr_en = 1'b1;
        @(negedge clk); tx_wr_en = 1'b0;
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b1) begin failures++; $display("FAIL a5_prestart: tx %b busy %b expected 1 1", tx, tx_busy); end
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== fr[i/16] || tx_busy !== 1'b1) begin
                failures++; $display("FAIL a5_line[%0d]: tx %b busy %b expected %b 1", i, tx, tx_busy, fr[i/16]);
            end
        end
        @(negedge clk);
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin failures++; $display("FAIL a5_done: tx %b busy %b expected 1 0", tx, tx_busy); end
    endtask

    task automatic test_loopback;
        int i;
        logic [23:0] exp;
        exp = 24'h3C_FF_00;
        loop_en = 1'b1; parity_mode = 2'b01; two_stop = 1'b1;
        repeat (4) @(negedge clk);
        tx_data = 8'h00; tx_wr_en = 1'b1;
        @(negedge clk); tx_data = 8'hFF;
        @(negedge clk); tx_data = 8'h3C;
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL loop_start: tx %b expected 0", tx); end
        @(negedge clk); tx_wr_en = 1'b0;
        i = 1;
        while (i < 800) begin
            @(negedge clk); i++;
            if (!tx_busy) break;
            if (i == 152 || i == 344) begin
                checks++; if (tx !== 1'b0) begin failures++; $display("FAIL loop_parity[%0d]: tx %b expected 0", i, tx); end
            end
            if (i == 168 || i == 184 || i == 216) begin
                checks++; if (tx !== 1'b1) begin failures++; $display("FAIL loop_high[%0d]: tx %b expected 1", i, tx); end
            end
            if (i == 200 || i == 392) begin
                checks++; if (tx !== 1'b0) begin failures++; $display("FAIL loop_nogap[%0d]: tx %b expected 0", i, tx); end
            end
        end
        checks++; if (i !== 576) begin failures++; $display("FAIL loop_duration: busy ended at %0d expected 576", i); end
        repeat (5) @(negedge clk);
        checks++; if (rx_count !== 3'd3) begin failures++; $display("FAIL loop_count: got %0d expected 3", rx_count); end
        checks++; if ({rx_frame_err, rx_parity_err, rx_overrun} !== 3'b000) begin failures++; $display("FAIL loop_flags: got %b expected 000", {rx_frame_err, rx_parity_err, rx_overrun}); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (rx_data !== exp[k*8 +: 8]) begin failures++; $display("FAIL loop_word%0d: got %h expected %h", k, rx_data, exp[k*8 +: 8]); end
            rx_rd_en = 1'b1; @(negedge clk); rx_rd_en = 1'b0;
        end
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL loop_empty: got %b expected 1", rx_empty); end
        loop_en = 1'b0;
    endtask

    task automatic test_parity_err;
        parity_mode = 2'b10; two_stop = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        drive_frame({1'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
        repeat (20) @(negedge clk);
        checks++; if (rx_count !== 3'd1 || rx_data !== 8'h55) begin failures++; $display("FAIL par_word: count %0d data %h expected 1 55", rx_count, rx_data); end
        checks++; if (rx_parity_err !== 1'b1 || rx_frame_err !== 1'b0) begin failures++; $display("FAIL par_flag: parity %b frame %b expected 1 0", rx_parity_err, rx_frame_err); end
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        checks++; if (rx_parity_err !== 1'b0) begin failures++; $display("FAIL par_clear: got %b expected 0", rx_parity_err); end
        rx_rd_en = 1'b1; @(negedge clk); rx_rd_en = 1'b0;
        checks++; if (rx_count !== 3'd0) begin failures++; $display("FAIL par_pop: count %0d expected 0", rx_count); end
    endtask

    task automatic test_frame_err;
        parity_mode = 2'b00; rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        drive_frame({2'b00, 1'b0, 8'hA7, 1'b0}, 10);
        repeat (32) @(negedge clk);
        checks++; if (rx_count !== 3'd0) begin failures++; $display("FAIL ferr_count: got %0d expected 0", rx_count); end
        checks++; if (rx_frame_err !== 1'b1) begin failures++; $display("FAIL ferr_flag: got %b expected 1", rx_frame_err); end
        drive_frame({2'b00, 1'b1, 8'h12, 1'b0}, 10);
        repeat (20) @(negedge clk);
        checks++; if (rx_count !== 3'd1 || rx_data !== 8'h12) begin failures++; $display("FAIL ferr_resync: count %0d data %h expected 1 12", rx_count, rx_data); end
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear: got %b expected 0", rx_frame_err); end
        rx_rd_en = 1'b1; @(negedge clk); rx_rd_en = 1'b0;
    endtask

    task automatic test_glitch;
        rx_drv = 1'b1; repeat (10) @(negedge clk);
        rx_drv = 1'b0; repeat (4) @(negedge clk);
        rx_drv = 1'b1; repeat (40) @(negedge clk);
        checks++; if (rx_count !== 3'd0) begin failures++; $display("FAIL glitch_count: got %0d expected 0", rx_count); end
        checks++; if ({rx_frame_err, rx_parity_err, rx_overrun} !== 3'b000) begin failures++; $display("FAIL glitch_flags: got %b expected 000", {rx_frame_err, rx_parity_err, rx_overrun}); end
        drive_frame({2'b00, 1'b1, 8'h6B, 1'b0}, 10);
        repeat (20) @(negedge clk);
        checks++; if (rx_count !== 3'd1 || rx_data !== 8'h6B) begin failures++; $display("FAIL glitch_after: count %0d data %h expected 1 6b", rx_count, rx_data); end
        rx_rd_en = 1'b1; @(negedge clk); rx_rd_en = 1'b0;
    endtask

    task automatic test_overrun;
        logic [39:0] w;
        int n;
        w = 40'h55_44_33_22_11;
        loop_en = 1'b1; parity_mode = 2'b00; two_stop = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            tx_data = w[k*8 +: 8]; tx_wr_en = 1'b1; @(negedge clk);
        end
        tx_data = 8'h99;
        checks++; if (tx_full !== 1'b1 || tx_count !== 3'd4) begin failures++; $display("FAIL ovr_txfull: full %b count %0d expected 1 4", tx_full, tx_count); end
        @(negedge clk); tx_wr_en = 1'b0;
        checks++; if (tx_count !== 3'd4) begin failures++; $display("FAIL ovr_txdrop: count %0d expected 4", tx_count); end
        n = 0;
        while (tx_busy && n < 2000) begin @(negedge clk); n++; end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL ovr_timeout: busy %b expected 0", tx_busy); end
        repeat (5) @(negedge clk);
        checks++; if (rx_count !== 3'd4) begin failures++; $display("FAIL ovr_count: got %0d expected 4", rx_count); end
        checks++; if (rx_overrun !== 1'b1 || rx_frame_err !== 1'b0 || rx_parity_err !== 1'b0) begin failures++; $display("FAIL ovr_flags: ovr %b frame %b par %b expected 1 0 0", rx_overrun, rx_frame_err, rx_parity_err); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rx_data !== w[k*8 +: 8]) begin failures++; $display("FAIL ovr_word%0d: got %h expected %h", k, rx_data, w[k*8 +: 8]); end
            if (k < 3) begin rx_rd_en = 1'b1; @(negedge clk); rx_rd_en = 1'b0; end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); tx_data = 8'h00; tx_wr_en = 1'b1;
        @(negedge clk); tx_data = 8'hF0;
        @(negedge clk); tx_wr_en = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (tx !== 1'b0 || tx_count !== 3'd1 || rx_count !== 3'd1) begin failures++; $display("FAIL mid_pre: tx %b txc %0d rxc %0d expected 0 1 1", tx, tx_count, rx_count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin failures++; $display("FAIL mid_tx: tx %b busy %b expected 1 0", tx, tx_busy); end
        checks++; if (tx_count !== 3'd0 || rx_count !== 3'd0 || rx_empty !== 1'b1) begin failures++; $display("FAIL mid_counts: txc %0d rxc %0d empty %b expected 0 0 1", tx_count, rx_count, rx_empty); end
        checks++; if ({rx_frame_err, rx_parity_err, rx_overrun} !== 3'b000 || rx_data !== 8'h00) begin failures++; $display("FAIL mid_flags: flags %b data %h expected 000 00", {rx_frame_err, rx_parity_err, rx_overrun}, rx_data); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        checks++; if (rx_count !== 3'd0 || tx !== 1'b1) begin failures++; $display("FAIL mid_after: rxc %0d tx %b expected 0 1", rx_count, tx); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_tx_a5;
        test_loopback;
        test_parity_err;
        test_frame_err;
        test_glitch;
        test_overrun;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
